// File: rtl/boe_if.sv
// boe_if: valid/ready sample input stream and tagged result output stream of boe_stream
interface boe_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter int NUM_W = $clog2(DEPTH + 1),
  parameter int RES_W = DATA_W + $clog2(DEPTH)
);
  logic in_valid, in_first, mode, in_ready;
  logic [NUM_W-1:0] data_num;
  logic [DATA_W-1:0] data_in;
  logic out_valid, out_ready, out_last;
  logic [1:0] out_kind;
  logic [RES_W-1:0] result;
  modport master (
    output in_valid, in_first, data_num, mode, data_in, out_ready,
    input in_ready, out_valid, out_kind, out_last, result
  );
  modport slave (
    input in_valid, in_first, data_num, mode, data_in, out_ready,
    output in_ready, out_valid, out_kind, out_last, result
  );
endinterface

// File: rtl/boe_stream.sv
// boe_stream: captures a frame of samples, then emits SUM, MAX, MIN and the samples replayed in reverse or forward order
module boe_stream #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter int NUM_W = $clog2(DEPTH + 1),
  parameter int RES_W = DATA_W + $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  boe_if.slave s,
  output logic busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int KW = NUM_W + 2;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
  state_t state, state_n;
  logic [NUM_W-1:0] cnt, cnt_n, n, n_n, dn;
  logic md, md_n, acc, start, wr, last_n;
  logic [RES_W-1:0] sum, sum_n, res_n;
  logic [DATA_W-1:0] mx, mx_n, mn, mn_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wa, ra;
  logic [KW-1:0] k, k_n, j;
  logic [1:0] kind_n;
  assign dn = (s.data_num == '0 || s.data_num > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : s.data_num;
  assign acc = s.in_valid && state != EMIT;
  assign start = acc && s.in_first;
  assign wr = start || (acc && state == LOAD);
  assign wa = start ? '0 : AW'(cnt);
  // k_n is the index of the beat to present next: 0..2 are statistics, 3.. are samples
  assign j = k_n - KW'(3);
  assign ra = md_n ? AW'(j) : AW'(KW'(n_n) - KW'(1) - j);
  assign kind_n = (k_n >= KW'(3)) ? 2'd3 : k_n[1:0];
  assign last_n = k_n == KW'(n_n) + KW'(2);
  assign res_n = kind_n == 2'd0 ? sum_n :
                 kind_n == 2'd1 ? RES_W'(mx_n) :
                 kind_n == 2'd2 ? RES_W'(mn_n) : RES_W'(mem[ra]);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    n_n = n;
    md_n = md;
    sum_n = sum;
    mx_n = mx;
    mn_n = mn;
    k_n = k;
    if (start) begin
      n_n = dn;
      md_n = s.mode;
      cnt_n = NUM_W'(1);
      sum_n = RES_W'(s.data_in);
      mx_n = s.data_in;
      mn_n = s.data_in;
      k_n = '0;
      state_n = dn == NUM_W'(1) ? EMIT : LOAD;
    end else if (acc && state == LOAD) begin
      cnt_n = cnt + NUM_W'(1);
      sum_n = sum + RES_W'(s.data_in);
      mx_n = s.data_in > mx ? s.data_in : mx;
      mn_n = s.data_in < mn ? s.data_in : mn;
      k_n = '0;
      state_n = cnt_n == n ? EMIT : LOAD;
    end else if (state == EMIT && s.out_valid && s.out_ready) begin
      k_n = k + KW'(1);
      state_n = s.out_last ? IDLE : EMIT;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      md <= 1'b0;
      sum <= '0;
      mx <= '0;
      mn <= '0;
      k <= '0;
      s.in_ready <= 1'b1;
      s.out_valid <= 1'b0;
      s.out_kind <= '0;
      s.out_last <= 1'b0;
      s.result <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      n <= n_n;
      md <= md_n;
      sum <= sum_n;
      mx <= mx_n;
      mn <= mn_n;
      k <= k_n;
      s.in_ready <= state_n != EMIT;
      s.out_valid <= state_n == EMIT;
      s.out_kind <= state_n == EMIT ? kind_n : '0;
      s.out_last <= state_n == EMIT && last_n;
      s.result <= state_n == EMIT ? res_n : '0;
      busy <= state_n != IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wa] <= s.data_in;
    end
  end
endmodule

// File: tb/tb_boe_stream.sv
// tb_boe_stream: randomized frames against a queue-based frame model; a negedge monitor scores every output beat
module tb_boe_stream;
  localparam int DATA_W = 8;
  localparam int DEPTH = 8;
  localparam int NUM_W = $clog2(DEPTH + 1);
  typedef struct {int kind; bit last; int val;} exp_t;
  logic clk = 0, rst = 0, busy;
  boe_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) b();
  boe_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .s(b), .busy(busy));
  always #5 clk = ~clk;
  exp_t sb[$];
  int smp[$];
  int checks = 0, errors = 0, popped = 0, rdy_mode = 0, cyc = 0, n_exp = 0;
  bit md_exp = 0, active = 0;

  function automatic void chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endfunction

  function automatic void push(int k, bit l, int v);
    exp_t e;
    e.kind = k;
    e.last = l;
    e.val = v;
    sb.push_back(e);
  endfunction

  // Frame model: collects accepted samples; a completed frame yields its N+3 expected beats
  function automatic bit model_accept(bit f, int dn, bit md, int d);
    int sum, mx, mn;
    if (f) begin
      n_exp = (dn == 0 || dn > DEPTH) ? DEPTH : dn;
      md_exp = md;
      smp.delete();
      active = 1;
    end
    if (!active) return 0;
    smp.push_back(d);
    if (smp.size() != n_exp) return 0;
    sum = 0; mx = 0; mn = 255;
    foreach (smp[i]) begin
      sum += smp[i];
      if (smp[i] > mx) mx = smp[i];
      if (smp[i] < mn) mn = smp[i];
    end
    push(0, 0, sum);
    push(1, 0, mx);
    push(2, 0, mn);
    for (int i = 0; i < n_exp; i++) push(3, i == n_exp - 1, md_exp ? smp[i] : smp[n_exp-1-i]);
    active = 0;
    return 1;
  endfunction

  task automatic beat(input bit f, input int dn, input bit md, input int d);
    bit got;
    int t;
    b.in_valid = 1; b.in_first = f; b.data_num = NUM_W'(dn); b.mode = md; b.data_in = DATA_W'(d);
    got = 0; t = 0;
    while (!got && t < 500) begin
      @(negedge clk); got = b.in_ready;
      @(posedge clk); #1; t++;
    end
    b.in_valid = 0; b.in_first = 0;
    if (!got) chk("in_ready timeout", 0, 1);
    else if (model_accept(f, dn, md, d)) begin
      chk("latency out_valid", b.out_valid, 1);
      chk("latency in_ready", b.in_ready, 0);
    end
  endtask

  task automatic frame(input int dn, input bit md, input int s[$], input int hold);
    foreach (s[i]) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      beat(i == 0, dn, md, s[i]);
    end
    if (hold > 0) begin
      b.in_valid = 1; b.in_first = 0;
      repeat (hold) @(posedge clk);
      #1 b.in_valid = 0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin @(posedge clk); t++; end
    chk("drain queue empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1; cyc++;
      b.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    exp_t e;
    bit held, last_seen;
    int hk, hl, hv;
    held = 0; last_seen = 0; hk = 0; hl = 0; hv = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0; last_seen = 0;
      end else begin
        if (last_seen) begin
          chk("idle after last busy", busy, 0);
          chk("idle after last in_ready", b.in_ready, 1);
          last_seen = 0;
        end
        if (held) begin
          chk("stall valid", b.out_valid, 1);
          chk("stall kind", b.out_kind, hk);
          chk("stall last", b.out_last, hl);
          chk("stall result", b.result, hv);
          held = 0;
        end
        if (b.out_valid) begin
          chk("in_ready during emit", b.in_ready, 0);
          if (b.out_ready) begin
            if (sb.size() == 0) chk("unexpected beat result", b.result, -1);
            else begin
              e = sb.pop_front();
              chk("kind", b.out_kind, e.kind);
              chk("last", b.out_last, e.last);
              chk("result", b.result, e.val);
            end
            popped++;
            last_seen = b.out_last;
          end else begin
            held = 1; hk = b.out_kind; hl = b.out_last; hv = b.result;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int p0, t, dn, len, md, pl;
    b.in_valid = 0; b.in_first = 0; b.data_num = '0; b.mode = 0; b.data_in = '0; b.out_ready = 1;
    #1 rst = 1;
    #2;
    chk("reset in_ready", b.in_ready, 1);
    chk("reset out_valid", b.out_valid, 0);
    chk("reset out_kind", b.out_kind, 0);
    chk("reset out_last", b.out_last, 0);
    chk("reset result", b.result, 0);
    chk("reset busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    rdy_mode = 0; q = '{3, 9, 1, 7};
    frame(4, 0, q, 0);
    drain();
    rdy_mode = 1;
    frame(4, 1, q, 0);
    drain();
    rdy_mode = 0; q = '{255, 255, 255, 255, 255, 255, 255, 255};
    frame(0, 0, q, 20);
    drain();
    q = '{42};
    frame(1, 0, q, 0);
    drain();
    beat(1, 5, 0, 10);
    beat(0, 5, 0, 20);
    q = '{5, 6};
    frame(2, 0, q, 0);
    drain();
    q = '{4, 5, 6};
    frame(3, 0, q, 0);
    p0 = popped; t = 0;
    while (popped == p0 && t < 100) begin @(posedge clk); t++; end
    chk("sum accepted before reset", int'(popped > p0), 1);
    #2 rst = 1;
    #1;
    chk("mid-emit reset out_valid", b.out_valid, 0);
    chk("mid-emit reset in_ready", b.in_ready, 1);
    chk("mid-emit reset out_kind", b.out_kind, 0);
    chk("mid-emit reset out_last", b.out_last, 0);
    chk("mid-emit reset result", b.result, 0);
    chk("mid-emit reset busy", busy, 0);
    sb.delete(); active = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    q = '{1, 2};
    frame(2, 0, q, 0);
    drain();
    for (int f = 0; f < 40; f++) begin
      rdy_mode = $urandom_range(0, 2);
      dn = $urandom_range(0, 12);
      len = (dn == 0 || dn > DEPTH) ? DEPTH : dn;
      md = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0 && len > 1) begin
        q.delete();
        pl = $urandom_range(1, len - 1);
        for (int i = 0; i < pl; i++) q.push_back($urandom_range(0, 255));
        frame(dn, md[0], q, 0);
      end
      q.delete();
      for (int i = 0; i < len; i++) q.push_back($urandom_range(0, 3) == 0 ? 255 * $urandom_range(0, 1) : $urandom_range(0, 255));
      frame(dn, md[0], q, $urandom_range(0, 3));
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/boe_stream.md
Name: boe_stream

Overview:
- Parametrised frame statistics and replay engine for the BOE datapath.
- Accepts a frame of 1..DEPTH unsigned samples over a valid/ready input stream.
- Emits, through a valid/ready output stream, a tagged sequence: SUM, MAX, MIN, then the stored samples in reverse or forward order.
- Sits between the sample source and the downstream result consumer. Both sides may stall.

Parameters:
- DATA_W, 8, sample width in bits (unsigned).
- DEPTH, 8, maximum samples per frame (>=2).
- NUM_W, $clog2(DEPTH+1), width of data_num.
- RES_W, DATA_W+$clog2(DEPTH), result width; the sum cannot overflow.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_first  in  1  marks first beat of a frame; qualifies data_num and mode.
- data_num  in  NUM_W  frame length, sampled on the first beat.
- mode  in  1  replay order, sampled on the first beat: 0 = reverse (last sample first), 1 = forward.
- data_in  in  DATA_W  sample.
- in_ready  out  1  input beat accepted when in_valid&in_ready.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts when out_valid&out_ready.
- out_kind  out  2  beat type: 0 = SUM, 1 = MAX, 2 = MIN, 3 = SAMPLE.
- out_last  out  1  high on the final beat of a frame's output.
- result  out  RES_W  beat payload; MAX, MIN and SAMPLE are zero-extended.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. Reset values: in_ready=1, out_valid=0, out_kind=0, out_last=0, result=0, busy=0. Internal count, sum, max, min and storage are cleared. FSM goes to IDLE.
- Reset asserted mid-frame aborts the frame immediately. No partial output is emitted afterwards.
- Length rule: data_num=0 or data_num>DEPTH is clamped to DEPTH. The effective length is N.
- IDLE:
  - in_ready=1.
  - A beat with in_first=1 captures N and mode, writes mem[0], and sets sum=max=min=data_in, cnt=1.
  - If N==1, go to EMIT. Otherwise go to LOAD.
  - Beats with in_first=0 are accepted and dropped.
- LOAD:
  - in_ready=1.
  - Each accepted beat writes mem[cnt], adds to sum, and updates max/min (unsigned compare). cnt increments.
  - in_valid low stalls; no state change.
  - The beat that makes cnt==N moves to EMIT on the next edge.
  - An accepted beat with in_first=1 in LOAD discards the partial frame and restarts capture exactly as from IDLE, using that beat.
- EMIT:
  - in_ready=0; input beats are not accepted.
  - The first output beat is presented the cycle after the last input beat is accepted (latency 1).
  - Output sequence: SUM, MAX, MIN, then N SAMPLE beats.
  - mode=0 replays mem[N-1] down to mem[0]; mode=1 replays mem[0] up to mem[N-1].
  - Each beat holds result, out_kind and out_last stable while out_valid&!out_ready.
  - The next beat is presented on the cycle after acceptance, so full throughput is one beat per cycle when out_ready is held high.
  - out_last=1 only on the final SAMPLE beat. Its acceptance returns the FSM to IDLE, with in_ready=1 on the following cycle.
- Total output beats per frame: N+3.
- No input is lost during EMIT, because in_ready=0 backpressures the source.
- Ties: MAX and MIN with equal samples report that value.
- Storage is DEPTH x DATA_W registers. Samples from a previous frame beyond N are never output.

Test Plan:
- DATA_W=8, DEPTH=8. Frame N=4, mode=0, samples 3,9,1,7, out_ready=1:
  - Output SUM=20, MAX=9, MIN=1, then 7,1,9,3.
  - out_last is high on the 3. First out_valid appears 1 cycle after the 4th input beat.
- Same samples with mode=1 and out_ready toggling 1,0,0,1…:
  - Output order is 20,9,1,3,9,1,7.
  - Payload is held stable during stalls. Exactly 7 beats are accepted.
- data_num=0 with 8 samples all 255:
  - Clamped to N=8. SUM=2040, MAX=MIN=255, then 8×255.
  - in_ready=0 throughout EMIT while in_valid stays high.
- N=1, sample 42:
  - Output SUM=42, MAX=42, MIN=42, SAMPLE=42 with out_last=1.
  - The FSM returns to IDLE on the cycle after out_last is accepted.
- Frame N=5 with 2 samples (10,20), then a beat with in_first=1, data_num=2, samples 5,6:
  - Partial frame is discarded. Output is 11,6,5,6,5 (mode=0).
- rst asserted during EMIT after the SUM beat:
  - All outputs return to reset values immediately.
  - A following frame N=2 of samples 1,2 outputs 3,2,1,2,1.
